imm_narrow: RTL

- Streaming narrowing unit: the inverse of the 5-to-8-bit immediate sign extender.
- Accepts 8-bit two's-complement ALU/register values and packs each into a 5-bit signed immediate field for the instruction encoder/assembler path.
- Flags every value that does not fit, and keeps overflow statistics.
- Valid/ready on both sides, 1-cycle latency, 2-entry skid so in_ready is fully registered.

---
 rtl/imm_pkg.sv | 26 ++
 rtl/imm_skid.sv | 88 ++++++++
 rtl/imm_narrow.sv | 92 +++++++++
 3 files changed

// File: rtl/imm_pkg.sv
// Shared constants, skid state encoding and fit helper for the immediate narrowing path.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package imm_pkg;

    localparam int IMM_IN_W  = 8;
    localparam int IMM_OUT_W = 5;
    localparam int IMM_MAX   = 15;
    localparam int IMM_MIN   = -16;

    // Occupancy of the output/skid register pair
    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // nothing held
        ONE   = 2'd1,   // output register full
        TWO   = 2'd2    // output and skid registers full
    } skid_state_e;

    // A value fits the immediate field when every bit from the field's sign
    // bit upward is a copy of it, i.e. the value is a pure sign extension.
    function automatic logic imm_fits(input logic [IMM_IN_W-1:0] din);
        logic [IMM_IN_W-IMM_OUT_W:0] upper;
        upper = din[IMM_IN_W-1:IMM_OUT_W-1];
        return (&upper) | ~(|upper);
    endfunction

endpackage

// File: rtl/imm_skid.sv
// 2-entry registered skid buffer: output register (OR) backed by one skid register (SK).
// Latency: 1 cycle from accept to out_valid when OR is empty or draining.
// Backpressure: in_ready is a flop (low only when both entries are full); no comb path from out_ready.
// Ports: clk/rst_n; in_valid/in_ready/in_data upstream; out_valid/out_ready/out_data downstream.
module imm_skid
    import imm_pkg::*;
#(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_e  state_q, state_d;
    logic [W-1:0] or_q, or_d;
    logic [W-1:0] sk_q, sk_d;
    logic         in_rdy_q, in_rdy_d;
    logic         out_vld_q, out_vld_d;
    logic         accept;
    logic         drain;

    assign accept = in_valid && in_rdy_q;
    assign drain  = out_vld_q && out_ready;

    always_comb begin
        state_d = state_q;
        or_d    = or_q;
        sk_d    = sk_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    or_d    = in_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && !drain) begin
                    sk_d    = in_data;
                    state_d = TWO;
                end else if (!accept && drain) begin
                    state_d = EMPTY;
                end else if (accept && drain) begin
                    or_d    = in_data;
                end
            end
            TWO: begin
                // in_ready is low here, so only a drain can happen
                if (drain) begin
                    or_d    = sk_q;
                    state_d = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        // Flags are derived from the next state so both come straight from flops
        in_rdy_d  = (state_d != TWO);
        out_vld_d = (state_d != EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            or_q      <= '0;
            sk_q      <= '0;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            or_q      <= or_d;
            sk_q      <= sk_d;
            in_rdy_q  <= in_rdy_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign in_ready  = in_rdy_q;
    assign out_valid = out_vld_q;
    assign out_data  = or_q;

endmodule

// File: rtl/imm_narrow.sv
// Narrows signed IN_W-bit values to a signed OUT_W-bit immediate, flags misfits, keeps overflow stats.
// Latency: 1 cycle accept-to-output through a 2-entry skid; stats update at the accept edge.
// Backpressure: registered in_ready, drops only when both skid entries are held.
// Ports: clk/rst_n; in_valid/in_ready/din; out_valid/out_ready/dout/out_ovf; ovf_count/ovf_sticky/clr_stats.
// Build option: define SATURATE_EN to clamp misfits to the field limits instead of truncating.
module imm_narrow
    import imm_pkg::*;
#(
    parameter int IN_W  = IMM_IN_W,
    parameter int OUT_W = IMM_OUT_W,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] dout,
    output logic             out_ovf,
    output logic [CNT_W-1:0] ovf_count,
    output logic             ovf_sticky,
    input  logic             clr_stats
);

    logic             fit;
    logic [OUT_W-1:0] narrowed;
    logic             accept;
    logic [OUT_W:0]   skid_out;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sticky_q, sticky_d;

    // Same test as imm_fits, written against the module widths
    always_comb begin
        fit      = (&din[IN_W-1:OUT_W-1]) | ~(|din[IN_W-1:OUT_W-1]);
        narrowed = din[OUT_W-1:0];
`ifdef SATURATE_EN
        if (!fit) begin
            narrowed = din[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                   : {1'b0, {(OUT_W-1){1'b1}}};
        end
`endif
    end

    assign accept = in_valid && in_ready;

    imm_skid #(
        .W (OUT_W + 1)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({~fit, narrowed}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (skid_out)
    );

    assign out_ovf = skid_out[OUT_W];
    assign dout    = skid_out[OUT_W-1:0];

    // Clear wins over a coincident overflow; the counter parks at all-ones
    always_comb begin
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        if (clr_stats) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
        end else if (accept && !fit) begin
            sticky_d = 1'b1;
            if (!(&cnt_q)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    assign ovf_count  = cnt_q;
    assign ovf_sticky = sticky_q;

endmodule
